// File: rtl/panda_pkg.sv
// Shared types for the Panda execute stage.
// Op codes, EX FSM states and op-class helpers.
package panda_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } ex_op_e;

    typedef enum logic [1:0] {
        EX_IDLE,
        EX_BUSY,
        EX_DONE
    } ex_state_e;

    function automatic logic is_muldiv(ex_op_e op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div(ex_op_e op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    function automatic logic is_rem(ex_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/panda_muldiv_iter.sv
// Radix-2 iterative multiplier / restoring divider.
// Works on magnitudes; signs are re-applied on the result.
module panda_muldiv_iter
    import panda_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  ex_op_e           op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             done,
    output logic [Width-1:0] result
);

    localparam int CntW = $clog2(Width) + 1;

    logic [Width-1:0]   hi_q;
    logic [Width-1:0]   lo_q;
    logic [Width-1:0]   dv_q;
    logic [CntW-1:0]    cnt_q;
    logic               run_q;
    logic               done_q;
    logic               neg_q;
    logic               neg_r_q;
    ex_op_e             op_q;

    logic               sa;
    logic               sb;
    logic [Width-1:0]   ma;
    logic [Width-1:0]   mb;
    logic [Width:0]     sum;
    logic [Width:0]     rem_t;
    logic [Width-1:0]   diff;
    logic [2*Width-1:0] prod;

    always_comb begin
        sa    = (op == OP_MULH || op == OP_MULHSU ||
                 op == OP_DIV  || op == OP_REM) && a[Width-1];
        sb    = (op == OP_MULH || op == OP_DIV ||
                 op == OP_REM) && b[Width-1];
        ma    = sa ? -a : a;
        mb    = sb ? -b : b;
        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
        rem_t = {hi_q, lo_q[Width-1]};
        diff  = rem_t[Width-1:0] - dv_q;
    end

    // mul: {hi,lo} is the product, lo shifts out the multiplier
    // div: hi is the partial remainder, lo shifts dividend -> quotient
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q    <= '0;
            lo_q    <= '0;
            dv_q    <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            op_q    <= OP_ADD;
        end else if (start) begin
            op_q    <= op;
            hi_q    <= '0;
            lo_q    <= is_div(op) ? ma : mb;
            dv_q    <= is_div(op) ? mb : ma;
            cnt_q   <= '0;
            run_q   <= 1'b1;
            done_q  <= 1'b0;
            neg_q   <= sa ^ sb;
            neg_r_q <= sa;
        end else if (run_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(Width - 1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
            if (!is_div(op_q)) begin
                hi_q <= sum[Width:1];
                lo_q <= {sum[0], lo_q[Width-1:1]};
            end else if (rem_t >= {1'b0, dv_q}) begin
                hi_q <= diff;
                lo_q <= {lo_q[Width-2:0], 1'b1};
            end else begin
                hi_q <= rem_t[Width-1:0];
                lo_q <= {lo_q[Width-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod   = {hi_q, lo_q};
        prod   = neg_q ? -prod : prod;
        result = '0;
        unique case (op_q)
            OP_MUL:    result = prod[Width-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  result = prod[2*Width-1:Width];
            OP_DIV,
            OP_DIVU:   result = neg_q ? -lo_q : lo_q;
            OP_REM,
            OP_REMU:   result = neg_r_q ? -hi_q : hi_q;
            default:   result = '0;
        endcase
    end

    assign done = done_q;

endmodule

// File: rtl/panda_ex_stage_mc.sv
// Panda execute stage: single-cycle ALU, iterative mul/div,
// valid/ready on both sides and a registered EX/MEM output.
module panda_ex_stage_mc
    import panda_pkg::*;
#(
    parameter int Width    = 32,
    parameter int RegAddrW = 5,
    parameter bit MulDivEn = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [4:0]          op_i,
    input  logic [Width-1:0]    operand_a_i,
    input  logic [Width-1:0]    operand_b_i,
    input  logic [RegAddrW-1:0] rd_addr_i,
    input  logic                rd_we_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [Width-1:0]    result_o,
    output logic [RegAddrW-1:0] rd_addr_o,
    output logic                rd_we_o,
    output logic                illegal_o,
    output logic                busy_o
);

    localparam int ShW = $clog2(Width);
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    ex_state_e           state_q;
    ex_op_e              op;
    logic                accept;
    logic                go_iter;
    logic                imm_ill;
    logic                alu_ok;
    logic                md_start;
    logic                md_done;
    logic [Width-1:0]    alu_res;
    logic [Width-1:0]    imm_res;
    logic [Width-1:0]    md_res;
    logic [ShW-1:0]      shamt;
    logic [RegAddrW-1:0] pend_addr_q;
    logic                pend_we_q;

    assign op       = ex_op_e'(op_i);
    assign shamt    = operand_b_i[ShW-1:0];
    assign ready_o  = (state_q == EX_IDLE) && (!valid_o || ready_i);
    assign busy_o   = (state_q != EX_IDLE);
    assign accept   = valid_i && ready_o;
    assign md_start = accept && go_iter && !flush_i;

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        unique case (op)
            OP_ADD:  alu_res = operand_a_i + operand_b_i;
            OP_SUB:  alu_res = operand_a_i - operand_b_i;
            OP_AND:  alu_res = operand_a_i & operand_b_i;
            OP_OR:   alu_res = operand_a_i | operand_b_i;
            OP_XOR:  alu_res = operand_a_i ^ operand_b_i;
            OP_SLL:  alu_res = operand_a_i << shamt;
            OP_SRL:  alu_res = operand_a_i >> shamt;
            OP_SRA:  alu_res = $signed(operand_a_i) >>> shamt;
            OP_SLT:  alu_res = Width'($signed(operand_a_i) <
                                      $signed(operand_b_i));
            OP_SLTU: alu_res = Width'(operand_a_i < operand_b_i);
            default: alu_ok  = 1'b0;
        endcase
    end

    // Divide-by-zero and MIN/-1 resolve here without iterating
    always_comb begin
        imm_res = alu_res;
        imm_ill = !alu_ok;
        go_iter = 1'b0;
        if (is_muldiv(op)) begin
            imm_res = '0;
            imm_ill = !MulDivEn;
            if (MulDivEn && is_div(op) && operand_b_i == '0) begin
                imm_res = is_rem(op) ? operand_a_i : '1;
            end else if (MulDivEn && (op == OP_DIV || op == OP_REM) &&
                         operand_a_i == MinVal && operand_b_i == '1) begin
                imm_res = (op == OP_REM) ? '0 : MinVal;
            end else if (MulDivEn) begin
                go_iter = 1'b1;
            end
        end
    end

    if (MulDivEn) begin : g_md
        panda_muldiv_iter #(
            .Width (Width)
        ) u_md (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .start  (md_start),
            .op     (op),
            .a      (operand_a_i),
            .b      (operand_b_i),
            .done   (md_done),
            .result (md_res)
        );
    end else begin : g_no_md
        assign md_done = 1'b0;
        assign md_res  = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= EX_IDLE;
            valid_o     <= 1'b0;
            result_o    <= '0;
            rd_addr_o   <= '0;
            rd_we_o     <= 1'b0;
            illegal_o   <= 1'b0;
            pend_addr_q <= '0;
            pend_we_q   <= 1'b0;
        end else if (flush_i) begin
            state_q   <= EX_IDLE;
            valid_o   <= 1'b0;
            rd_we_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            unique case (state_q)
                EX_IDLE: begin
                    if (accept && go_iter) begin
                        state_q     <= EX_BUSY;
                        pend_addr_q <= rd_addr_i;
                        pend_we_q   <= rd_we_i;
                    end else if (accept) begin
                        valid_o   <= 1'b1;
                        result_o  <= imm_ill ? '0 : imm_res;
                        rd_addr_o <= rd_addr_i;
                        rd_we_o   <= rd_we_i && !imm_ill;
                        illegal_o <= imm_ill;
                    end
                end
                EX_BUSY: begin
                    if (md_done) begin
                        state_q <= EX_DONE;
                    end
                end
                EX_DONE: begin
                    state_q   <= EX_IDLE;
                    valid_o   <= 1'b1;
                    result_o  <= md_res;
                    rd_addr_o <= pend_addr_q;
                    rd_we_o   <= pend_we_q;
                    illegal_o <= 1'b0;
                end
                default: state_q <= EX_IDLE;
            endcase
        end
    end

endmodule
